// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the memory slave.
//   WB_AW / WB_DW : bus address / data widths
//   wb_resp_t     : one response-pipeline entry {valid, data}
//   LFSR_TAPS     : feedback mask for the 16-bit Fibonacci stall LFSR (x^16+x^14+x^13+x^11+1)
//   lfsr_next()   : one LFSR step
package wb_pkg;

  localparam int unsigned WB_AW = 16;
  localparam int unsigned WB_DW = 16;

  typedef struct packed {
    logic             valid;
    logic [WB_DW-1:0] data;
  } wb_resp_t;

  // Taps 16,14,13,11 map to register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Fixed-length response pipeline for wb_mem_slave.
//   clk_i : clock, rising edge
//   flush : synchronous clear of every stage (valid and data)
//   din   : entry loaded into stage 0 each cycle
//   dout  : last stage
module wb_delay_line
  import wb_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     clk_i,
  input  logic     flush,
  input  wb_resp_t din,
  output wb_resp_t dout
);

  wb_resp_t stage [LATENCY];

  always_ff @(posedge clk_i) begin
    if (flush) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave in front of a single-port 16-bit RAM.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset (pipeline, stall logic; RAM untouched)
//   wb_cyc_i    : bus cycle active; low flushes all in-flight responses
//   wb_stb_i    : request strobe
//   wb_stall_o  : request not accepted this cycle (optional pseudo-random)
//   wb_addr_i   : word address, only [ADDR_BITS-1:0] decoded
//   wb_we_i     : 1 = write, 0 = read
//   wb_wrdat_i  : write data
//   wb_ack_o    : one response per accepted request, LATENCY cycles later
//   wb_data_o   : read data on read acks, 0 otherwise
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter string       INIT_FILE = ""
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic             wb_stall_o,
  input  logic [WB_AW-1:0] wb_addr_i,
  input  logic             wb_we_i,
  input  logic [WB_DW-1:0] wb_wrdat_i,
  output logic             wb_ack_o,
  output logic [WB_DW-1:0] wb_data_o
);

  logic [WB_DW-1:0] mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] addr;
  logic                 accept;
  wb_resp_t             resp_in;
  wb_resp_t             resp_out;

  assign addr   = wb_addr_i[ADDR_BITS-1:0];
  assign accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  // Reset wins over a same-edge accept, so the write is suppressed here.
  always_ff @(posedge clk_i) begin
    if (accept && wb_we_i && !rst_i) begin
      mem[addr] <= wb_wrdat_i;
    end
  end

  // Stage 0 of the delay line acts as the RAM read register; data is
  // forced to 0 for writes and idle cycles so wb_data_o is 0 without ack.
  always_comb begin
    resp_in.valid = accept;
    resp_in.data  = '0;
    if (accept && !wb_we_i) begin
      resp_in.data = mem[addr];
    end
  end

  wb_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk_i(clk_i),
    .flush(rst_i | ~wb_cyc_i),
    .din  (resp_in),
    .dout (resp_out)
  );

  assign wb_ack_o  = resp_out.valid;
  assign wb_data_o = resp_out.data;

  // Stall generator: ~25% duty from two LFSR bits, with runs capped at
  // three cycles by forcing a release once run_cnt reaches 3.
  logic [15:0] lfsr;
  logic [1:0]  run_cnt;
  logic        stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr    <= LFSR_SEED;
      run_cnt <= '0;
      stall_q <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (STALL_EN && lfsr[0] && lfsr[1] && run_cnt != 2'd3) begin
        stall_q <= 1'b1;
        run_cnt <= run_cnt + 2'd1;
      end else begin
        stall_q <= 1'b0;
        run_cnt <= '0;
      end
    end
  end

  assign wb_stall_o = stall_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
module tb_wb_mem_slave;

  localparam int N = 4;
  localparam int unsigned LAT [N] = '{2, 3, 4, 2};
  localparam bit          SEN [N] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [N];
  logic        cyc   [N];
  logic        stb   [N];
  logic        we    [N];
  logic        stall [N];
  logic        ack   [N];
  logic [15:0] addr  [N];
  logic [15:0] wdat  [N];
  logic [15:0] rdat  [N];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      wb_mem_slave #(
        .ADDR_BITS(12),
        .LATENCY  (LAT[g]),
        .STALL_EN (SEN[g]),
        .LFSR_SEED(16'hACE1),
        .INIT_FILE("")
      ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst[g]),
        .wb_cyc_i  (cyc[g]),
        .wb_stb_i  (stb[g]),
        .wb_stall_o(stall[g]),
        .wb_addr_i (addr[g]),
        .wb_we_i   (we[g]),
        .wb_wrdat_i(wdat[g]),
        .wb_ack_o  (ack[g]),
        .wb_data_o (rdat[g])
      );
    end
  endgenerate

  int unsigned cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct {
    logic [15:0] data;
    int unsigned due;
  } exp_t;

  exp_t        exp_q [N][$];
  logic [15:0] model [N][4096];
  int          tests = 0;
  int          fails = 0;
  int          stall_run = 0;
  bit          rst_chk = 1'b0;
  bit          end_chk = 1'b0;

  // Drive one cycle on instance i. Called just after a rising edge; the
  // request is accepted on the next edge if cyc&stb and no stall now.
  task automatic drive(input int i, input bit c, input bit s, input bit w,
                       input logic [15:0] a, input logic [15:0] d, input bit r,
                       output bit acc);
    exp_t e;
    cyc[i] = c; stb[i] = s; we[i] = w; addr[i] = a; wdat[i] = d; rst[i] = r;
    acc = !r && c && s && (stall[i] === 1'b0);
    if (acc) begin
      if (w) model[i][a[11:0]] = d;
      e.data = w ? 16'h0000 : model[i][a[11:0]];
      e.due  = cnt + LAT[i];
      exp_q[i].push_back(e);
    end
    @(posedge clk); #1;
    if (!c || r) exp_q[i].delete();
  endtask

  task automatic req(input int i, input bit w, input logic [15:0] a, input logic [15:0] d);
    bit acc;
    drive(i, 1'b1, 1'b1, w, a, d, 1'b0, acc);
  endtask

  task automatic idle(input int i, input int n);
    bit acc;
    for (int k = 0; k < n; k++) drive(i, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        tests++;
        if (exp_q[i].size() == 0) begin
          fails++;
          $display("FAIL ack_unexpected dut%0d: got ack data=%h at cycle %0d, required no ack", i, rdat[i], cnt);
        end else begin
          e = exp_q[i].pop_front();
          if (rdat[i] !== e.data || cnt != e.due) begin
            fails++;
            $display("FAIL ack_resp dut%0d: got data=%h at cycle %0d, required data=%h at cycle %0d",
                     i, rdat[i], cnt, e.data, e.due);
          end
        end
      end else begin
        if (exp_q[i].size() != 0 && exp_q[i][0].due <= cnt) begin
          tests++; fails++;
          $display("FAIL ack_missing dut%0d: got no ack at cycle %0d, required data=%h due cycle %0d",
                   i, cnt, exp_q[i][0].data, exp_q[i][0].due);
          void'(exp_q[i].pop_front());
        end
        tests++;
        if (rdat[i] !== 16'h0000) begin
          fails++;
          $display("FAIL idle_data dut%0d: got %h without ack, required 0000", i, rdat[i]);
        end
      end
      if (!SEN[i]) begin
        tests++;
        if (stall[i] !== 1'b0) begin
          fails++;
          $display("FAIL stall_off dut%0d: got %b, required 0", i, stall[i]);
        end
      end
    end
    if (stall[3] === 1'b1) begin
      stall_run++;
      tests++;
      if (stall_run > 3) begin
        fails++;
        $display("FAIL stall_run: got %0d consecutive stall cycles, required <= 3", stall_run);
      end
    end else begin
      stall_run = 0;
    end
    tests++;
    if (exp_q[3].size() > int'(LAT[3])) begin
      fails++;
      $display("FAIL outstanding: got %0d, required <= %0d", exp_q[3].size(), LAT[3]);
    end
    if (rst_chk) begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (ack[i] !== 1'b0 || rdat[i] !== 16'h0000 || stall[i] !== 1'b0) begin
          fails++;
          $display("FAIL reset_state dut%0d: got ack=%b data=%h stall=%b, required 0/0000/0",
                   i, ack[i], rdat[i], stall[i]);
        end
      end
    end
    if (end_chk) begin
      for (int i = 0; i < N; i++) begin
        tests++;
        if (exp_q[i].size() != 0) begin
          fails++;
          $display("FAIL drain dut%0d: got %0d responses outstanding, required 0", i, exp_q[i].size());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      addr[i] = 16'h0; wdat[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    rst_chk = 1'b1;
    @(negedge clk); #1;
    rst_chk = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: write then read-after-write
    req(0, 1'b1, 16'h0010, 16'hBEEF);
    req(0, 1'b0, 16'h0010, 16'h0);
    idle(0, 5);

    // Address aliasing: F005 and 0005 are the same word
    req(0, 1'b1, 16'hF005, 16'h1234);
    req(0, 1'b0, 16'h0005, 16'h0);
    idle(0, 5);

    // Reset beats a same-edge write; reset also drops an in-flight read
    req(0, 1'b1, 16'h0020, 16'h0000);
    idle(0, 4);
    drive(0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555, 1'b1, acc);
    req(0, 1'b0, 16'h0020, 16'h0);
    idle(0, 4);
    req(0, 1'b0, 16'h0010, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, acc);
    idle(0, 5);

    // LATENCY=3: back-to-back reads return back-to-back acks in order
    for (int k = 0; k < 4; k++) req(1, 1'b1, 16'(k), 16'h1000 + 16'(k));
    idle(1, 5);
    for (int k = 0; k < 4; k++) req(1, 1'b0, 16'(k), 16'h0);
    idle(1, 6);

    // LATENCY=4: abort drops in-flight reads, later read acks normally
    req(2, 1'b1, 16'h0040, 16'hA5A5);
    req(2, 1'b1, 16'h0041, 16'h5A5A);
    idle(2, 6);
    req(2, 1'b0, 16'h0040, 16'h0);
    req(2, 1'b0, 16'h0041, 16'h0);
    drive(2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, acc);
    req(2, 1'b0, 16'h0041, 16'h0);
    idle(2, 8);

    // STALL_EN=1: preload 0..7, then random traffic
    for (int k = 0; k < 8; k++) begin
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++)
        drive(3, 1'b1, 1'b1, 1'b1, 16'(k), 16'hC000 + 16'(k * 17), 1'b0, acc);
    end
    idle(3, 4);
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 7)) | (16'($urandom_range(0, 15)) << 12);
      drive(3, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            a, 16'($urandom), 1'b0, acc);
    end
    idle(3, 8);

    end_chk = 1'b1;
    @(negedge clk); #1;
    end_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
